// File: rtl/branch_predict_ctrl_pkg.sv
// Shared types for the branch predictor: BHT counter, controller state, counter update.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package branch_predict_ctrl_pkg;

  typedef logic [1:0] bht_ctr_t;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    IDLE  = 2'd1,
    FLUSH = 2'd2
  } bp_state_t;

  // Weakly not-taken: one taken outcome is enough to flip the prediction.
  localparam bht_ctr_t BHT_WNT = 2'b01;

  // Two-bit saturating counter step toward the resolved outcome.
  function automatic bht_ctr_t sat_update(bht_ctr_t ctr, logic taken);
    if (taken) begin
      return (ctr == 2'b11) ? ctr : ctr + 2'b01;
    end
    return (ctr == 2'b00) ? ctr : ctr - 2'b01;
  endfunction

endpackage

// File: rtl/branch_predict_ctrl_if.sv
// Fetch-side prediction bus and execute-side resolution bus of the branch predictor.
// Latency: n/a (wires only).
// Backpressure: none; the core samples predictions combinationally.
interface branch_predict_ctrl_if #(
  parameter int XLEN = 32
);
  logic            fetch_valid;
  logic [XLEN-1:0] fetch_pc;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;

  logic            ex_valid;
  logic            ex_is_branch;
  logic [XLEN-1:0] ex_pc;
  logic            ex_take_branch;
  logic [XLEN-1:0] ex_target;
  logic            ex_pred_taken;
  logic [XLEN-1:0] ex_pred_target;

  // Core pipeline side
  modport master (
    output fetch_valid, fetch_pc,
    output ex_valid, ex_is_branch, ex_pc, ex_take_branch, ex_target,
    output ex_pred_taken, ex_pred_target,
    input  pred_taken, pred_target
  );

  // Predictor side
  modport slave (
    input  fetch_valid, fetch_pc,
    input  ex_valid, ex_is_branch, ex_pc, ex_take_branch, ex_target,
    input  ex_pred_taken, ex_pred_target,
    output pred_taken, pred_target
  );
endinterface

// File: rtl/branch_predict_ctrl_bp_tables.sv
// BHT + direct-mapped BTB storage: one combinational lookup port, one clocked write port.
// Latency: lookup 0 cycles; writes visible the cycle after wr_en_i (no read bypass).
// Backpressure: none; a write is accepted every cycle wr_en_i is high.
module bp_tables
  import branch_predict_ctrl_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 64,
  localparam int INDEX_W = $clog2(ENTRIES),
  localparam int TAG_W   = XLEN - INDEX_W - 2
) (
  input  logic               clk,
  input  logic [INDEX_W-1:0] rd_idx_i,
  input  logic [TAG_W-1:0]   rd_tag_i,
  output logic               rd_taken_o,
  output logic               rd_hit_o,
  output logic [XLEN-1:0]    rd_target_o,
  input  logic               wr_en_i,
  input  logic               wr_init_i,
  input  logic [INDEX_W-1:0] wr_idx_i,
  input  logic               wr_taken_i,
  input  logic [TAG_W-1:0]   wr_tag_i,
  input  logic [XLEN-1:0]    wr_target_i
);

  bht_ctr_t         bht_q     [ENTRIES];
  logic             btb_vld_q [ENTRIES];
  logic [TAG_W-1:0] btb_tag_q [ENTRIES];
  logic [XLEN-1:0]  btb_tgt_q [ENTRIES];

  assign rd_taken_o  = bht_q[rd_idx_i][1];
  assign rd_hit_o    = btb_vld_q[rd_idx_i] && (btb_tag_q[rd_idx_i] == rd_tag_i);
  assign rd_target_o = btb_tgt_q[rd_idx_i];

  // Init sweep clears one entry; otherwise train the counter and learn taken targets
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      if (wr_init_i) begin
        bht_q[wr_idx_i]     <= BHT_WNT;
        btb_vld_q[wr_idx_i] <= 1'b0;
      end else begin
        bht_q[wr_idx_i] <= sat_update(bht_q[wr_idx_i], wr_taken_i);
        if (wr_taken_i) begin
          btb_vld_q[wr_idx_i] <= 1'b1;
          btb_tag_q[wr_idx_i] <= wr_tag_i;
          btb_tgt_q[wr_idx_i] <= wr_target_i;
        end
      end
    end
  end

endmodule

// File: rtl/branch_predict_ctrl.sv
// Branch predictor controller: fetch prediction, execute-side training, mispredict flush/redirect.
// Latency: prediction 0 cycles; mispredict to redirect_o 1 cycle; flush_o held FLUSH_CYCLES.
// Backpressure: none; resolutions arriving during INIT or FLUSH are dropped as wrong-path.
module branch_predict_ctrl
  import branch_predict_ctrl_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int BHT_ENTRIES  = 64,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  branch_predict_ctrl_if.slave  bp,
  output logic                  ready_o,
  output logic                  flush_o,
  output logic                  redirect_o,
  output logic [XLEN-1:0]       redirect_pc,
  output logic [31:0]           mispredict_cnt
);

  localparam int INDEX_W = $clog2(BHT_ENTRIES);
  localparam int TAG_W   = XLEN - INDEX_W - 2;
  localparam int FC_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [INDEX_W-1:0] LAST_IDX = INDEX_W'(BHT_ENTRIES - 1);
  localparam logic [FC_W-1:0]    FC_LOAD  = FC_W'(FLUSH_CYCLES - 1);

  bp_state_t          state_q, state_d;
  logic [INDEX_W-1:0] init_idx_q, init_idx_d;
  logic [FC_W-1:0]    flush_cnt_q, flush_cnt_d;
  logic               flush_q, flush_d;
  logic               redirect_q, redirect_d;
  logic [XLEN-1:0]    redirect_pc_q, redirect_pc_d;
  logic [31:0]        cnt_q, cnt_d;

  logic               rd_taken, rd_hit;
  logic [XLEN-1:0]    rd_target;
  logic               wr_en, wr_init;
  logic [INDEX_W-1:0] wr_idx;
  logic               resolve, mispredict;

  assign resolve    = bp.ex_valid && bp.ex_is_branch;
  assign mispredict = (bp.ex_take_branch != bp.ex_pred_taken) ||
                      (bp.ex_take_branch && bp.ex_pred_taken &&
                       (bp.ex_target != bp.ex_pred_target));

  bp_tables #(.XLEN(XLEN), .ENTRIES(BHT_ENTRIES)) u_tables (
    .clk         (clk),
    .rd_idx_i    (bp.fetch_pc[INDEX_W+1:2]),
    .rd_tag_i    (bp.fetch_pc[XLEN-1:INDEX_W+2]),
    .rd_taken_o  (rd_taken),
    .rd_hit_o    (rd_hit),
    .rd_target_o (rd_target),
    .wr_en_i     (wr_en),
    .wr_init_i   (wr_init),
    .wr_idx_i    (wr_idx),
    .wr_taken_i  (bp.ex_take_branch),
    .wr_tag_i    (TAG_W'(bp.ex_pc[XLEN-1:INDEX_W+2])),
    .wr_target_i (bp.ex_target)
  );

  // Tables hold garbage until the sweep finishes, so predictions are suppressed in INIT
  assign bp.pred_taken  = bp.fetch_valid && (state_q != INIT) && rd_taken && rd_hit;
  assign bp.pred_target = bp.pred_taken ? rd_target : bp.fetch_pc + XLEN'(4);

  assign ready_o        = (state_q != INIT);
  assign flush_o        = flush_q;
  assign redirect_o     = redirect_q;
  assign redirect_pc    = redirect_pc_q;
  assign mispredict_cnt = cnt_q;

  // State and registered recovery outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= INIT;
      init_idx_q    <= '0;
      flush_cnt_q   <= '0;
      flush_q       <= 1'b0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      init_idx_q    <= init_idx_d;
      flush_cnt_q   <= flush_cnt_d;
      flush_q       <= flush_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      cnt_q         <= cnt_d;
    end
  end

  // Next state, table write control and mispredict recovery sequencing
  always_comb begin
    state_d       = state_q;
    init_idx_d    = init_idx_q;
    flush_cnt_d   = flush_cnt_q;
    flush_d       = flush_q;
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc_q;
    cnt_d         = cnt_q;
    wr_en         = 1'b0;
    wr_init       = 1'b0;
    wr_idx        = bp.ex_pc[INDEX_W+1:2];
    unique case (state_q)
      INIT: begin
        wr_en      = 1'b1;
        wr_init    = 1'b1;
        wr_idx     = init_idx_q;
        init_idx_d = init_idx_q + 1'b1;
        flush_d    = 1'b0;
        if (init_idx_q == LAST_IDX) state_d = IDLE;
      end
      IDLE: begin
        if (resolve) begin
          wr_en = 1'b1;
          if (mispredict) begin
            flush_d       = 1'b1;
            redirect_d    = 1'b1;
            redirect_pc_d = bp.ex_take_branch ? bp.ex_target : bp.ex_pc + XLEN'(4);
            cnt_d         = cnt_q + 32'd1;
            flush_cnt_d   = FC_LOAD;
            state_d       = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (flush_cnt_q == '0) begin
          flush_d = 1'b0;
          state_d = IDLE;
        end else begin
          flush_cnt_d = flush_cnt_q - 1'b1;
        end
      end
      default: state_d = INIT;
    endcase
  end

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Self-checking bench for branch_predict_ctrl: reference model plus directed scenarios.
module tb_branch_predict_ctrl;

  localparam int N  = 64;
  localparam int FC = 2;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        ready_o, flush_o, redirect_o;
  logic [31:0] redirect_pc, mispredict_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_predict_ctrl_if #(.XLEN(32)) bus ();

  branch_predict_ctrl #(.XLEN(32), .BHT_ENTRIES(N), .FLUSH_CYCLES(FC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bp             (bus),
    .ready_o        (ready_o),
    .flush_o        (flush_o),
    .redirect_o     (redirect_o),
    .redirect_pc    (redirect_pc),
    .mispredict_cnt (mispredict_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_bht [N];
  bit          m_vld [N];
  logic [31:0] m_tag [N];
  logic [31:0] m_tgt [N];
  int          m_init_left  = N;
  int          m_flush_left = 0;
  bit          m_redirect   = 1'b0;
  logic [31:0] m_rpc        = '0;
  logic [31:0] m_cnt        = '0;

  always @(posedge clk or negedge rst_n) begin
    int i;
    bit tk, wrong;
    if (!rst_n) begin
      m_init_left  = N;
      m_flush_left = 0;
      m_redirect   = 1'b0;
      m_rpc        = '0;
      m_cnt        = '0;
    end else begin
      m_redirect = 1'b0;
      if (m_init_left > 0) begin
        i          = N - m_init_left;
        m_bht[i]   = 1;
        m_vld[i]   = 1'b0;
        m_init_left--;
      end else if (m_flush_left > 0) begin
        m_flush_left--;
      end else if (bus.ex_valid && bus.ex_is_branch) begin
        i  = int'((bus.ex_pc >> 2) % N);
        tk = bus.ex_take_branch;
        if (tk) begin
          if (m_bht[i] < 3) m_bht[i]++;
          m_vld[i] = 1'b1;
          m_tag[i] = bus.ex_pc >> 8;
          m_tgt[i] = bus.ex_target;
        end else if (m_bht[i] > 0) begin
          m_bht[i]--;
        end
        wrong = (tk != bus.ex_pred_taken) || (tk && bus.ex_target != bus.ex_pred_target);
        if (wrong) begin
          m_flush_left = FC;
          m_redirect   = 1'b1;
          m_rpc        = tk ? bus.ex_target : bus.ex_pc + 32'd4;
          m_cnt        = m_cnt + 32'd1;
        end
      end
    end
  end

  // Every-cycle comparison against the model, after stimulus has settled
  initial begin
    int          i;
    logic        e_pt;
    logic [31:0] e_tgt;
    forever begin
      @(negedge clk);
      #2;
      i     = int'((bus.fetch_pc >> 2) % N);
      e_pt  = (m_init_left == 0) && bus.fetch_valid && (m_bht[i] >= 2) && m_vld[i] &&
              (m_tag[i] == (bus.fetch_pc >> 8));
      e_tgt = e_pt ? m_tgt[i] : bus.fetch_pc + 32'd4;
      chk("cmp_ready",    ready_o,         (m_init_left == 0));
      chk("cmp_pred",     bus.pred_taken,  e_pt);
      chk("cmp_ptarget",  bus.pred_target, e_tgt);
      chk("cmp_flush",    flush_o,         (m_flush_left > 0));
      chk("cmp_redirect", redirect_o,      m_redirect);
      chk("cmp_rpc",      redirect_pc,     m_rpc);
      chk("cmp_cnt",      mispredict_cnt,  m_cnt);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ready(input string nm);
    int cyc = 0;
    bit bad = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      cyc++;
      bus.fetch_pc = $urandom & 32'hFFFF_FFFC;
      #1;
      if (ready_o) break;
      if (bus.pred_taken !== 1'b0) bad = 1'b1;
    end
    chk({nm, "_cycles"}, cyc, 64);
    chk({nm, "_pred0"}, bad, 0);
    step();
  endtask

  task automatic resolve(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                         input logic ptk, input logic [31:0] ptgt);
    bus.ex_valid       = 1'b1;
    bus.ex_is_branch   = 1'b1;
    bus.ex_pc          = pc;
    bus.ex_take_branch = tk;
    bus.ex_target      = tgt;
    bus.ex_pred_taken  = ptk;
    bus.ex_pred_target = ptgt;
    step();
    bus.ex_valid     = 1'b0;
    bus.ex_is_branch = 1'b0;
  endtask

  task automatic wait_flush();
    for (int k = 0; k < 8 && flush_o; k++) step();
    chk("flush_end", flush_o, 0);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int fl, rd;
    bus.fetch_valid    = 1'b1;
    bus.fetch_pc       = '0;
    bus.ex_valid       = 1'b0;
    bus.ex_is_branch   = 1'b0;
    bus.ex_pc          = '0;
    bus.ex_take_branch = 1'b0;
    bus.ex_target      = '0;
    bus.ex_pred_taken  = 1'b0;
    bus.ex_pred_target = '0;

    // Reset values, then init sweep length
    repeat (3) step();
    chk("rst_ready", ready_o, 0);
    chk("rst_flush", flush_o, 0);
    chk("rst_redir", redirect_o, 0);
    chk("rst_rpc", redirect_pc, 0);
    chk("rst_cnt", mispredict_cnt, 0);
    rst_n = 1'b1;
    wait_ready("init");

    // Taken branch at 0x100 learned after one resolve
    bus.fetch_pc = 32'h100;
    #1;
    chk("cold_pred", bus.pred_taken, 0);
    resolve(32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
    chk("t2_redir", redirect_o, 1);
    chk("t2_rpc", redirect_pc, 32'h80);
    chk("t2_cnt", mispredict_cnt, 1);
    chk("t2_pred", bus.pred_taken, 1);
    chk("t2_ptgt", bus.pred_target, 32'h80);
    wait_flush();
    resolve(32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
    chk("t2_ok_redir", redirect_o, 0);
    chk("t2_ok_cnt", mispredict_cnt, 1);

    // Predicted taken, actually not taken: fall-through redirect, 2-cycle flush
    resolve(32'h208, 1'b0, 32'h240, 1'b1, 32'h240);
    chk("t3_rpc", redirect_pc, 32'h20C);
    chk("t3_cnt", mispredict_cnt, 2);
    fl = 0;
    rd = 0;
    for (int k = 0; k < 5; k++) begin
      fl += int'(flush_o);
      rd += int'(redirect_o);
      step();
    end
    chk("t3_flush_len", fl, 2);
    chk("t3_redir_len", rd, 1);

    // Target mismatch on a correctly predicted taken branch
    bus.fetch_pc = 32'h30C;
    resolve(32'h30C, 1'b1, 32'h60, 1'b1, 32'h40);
    chk("t4_rpc", redirect_pc, 32'h60);
    chk("t4_cnt", mispredict_cnt, 3);
    chk("t4_pred", bus.pred_taken, 1);
    chk("t4_ptgt", bus.pred_target, 32'h60);
    wait_flush();

    // Resolutions during FLUSH are wrong-path and must be ignored
    resolve(32'h410, 1'b1, 32'h500, 1'b0, 32'h0);
    chk("t5_cnt", mispredict_cnt, 4);
    bus.ex_valid       = 1'b1;
    bus.ex_is_branch   = 1'b1;
    bus.ex_pc          = 32'h100;
    bus.ex_take_branch = 1'b0;
    bus.ex_target      = 32'h999C;
    bus.ex_pred_taken  = 1'b1;
    bus.ex_pred_target = 32'h80;
    step();
    step();
    bus.ex_valid     = 1'b0;
    bus.ex_is_branch = 1'b0;
    chk("t5_flush_off", flush_o, 0);
    chk("t5_cnt_hold", mispredict_cnt, 4);
    bus.fetch_pc = 32'h100;
    #1;
    chk("t5_bht_hold", bus.pred_taken, 1);
    chk("t5_btb_hold", bus.pred_target, 32'h80);
    // Non-branch instruction with would-be-mispredict fields
    bus.ex_valid       = 1'b1;
    bus.ex_is_branch   = 1'b0;
    bus.ex_take_branch = 1'b0;
    bus.ex_pred_taken  = 1'b1;
    step();
    bus.ex_valid = 1'b0;
    chk("t5_nonbr_flush", flush_o, 0);
    chk("t5_nonbr_cnt", mispredict_cnt, 4);

    // Saturation: four taken, then one not-taken still predicts taken
    bus.fetch_pc = 32'h514;
    for (int k = 0; k < 4; k++) resolve(32'h514, 1'b1, 32'h540, 1'b1, 32'h540);
    chk("t6_nomis", mispredict_cnt, 4);
    resolve(32'h514, 1'b0, 32'h540, 1'b1, 32'h540);
    chk("t6_cnt", mispredict_cnt, 5);
    chk("t6_still_t", bus.pred_taken, 1);
    chk("t6_ptgt", bus.pred_target, 32'h540);
    wait_flush();
    bus.fetch_pc = 32'h614;
    #1;
    chk("t6_tag_miss", bus.pred_taken, 0);
    chk("t6_tag_miss_tgt", bus.pred_target, 32'h618);
    bus.fetch_pc = 32'h514;
    resolve(32'h514, 1'b0, 32'h540, 1'b1, 32'h540);
    chk("t6_now_nt", bus.pred_taken, 0);
    chk("t6_nt_tgt", bus.pred_target, 32'h518);
    wait_flush();

    // Reset in the first FLUSH cycle
    resolve(32'h618, 1'b1, 32'h700, 1'b0, 32'h0);
    chk("t7_flush_on", flush_o, 1);
    chk("t7_cnt", mispredict_cnt, 7);
    rst_n = 1'b0;
    #1;
    chk("t7_flush_drop", flush_o, 0);
    chk("t7_redir_drop", redirect_o, 0);
    chk("t7_cnt_clr", mispredict_cnt, 0);
    chk("t7_ready_clr", ready_o, 0);
    step();
    rst_n = 1'b1;
    wait_ready("reinit");
    bus.fetch_pc = 32'h100;
    #1;
    chk("t7_tables_clr", bus.pred_taken, 0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
